// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/mem/writeback.
// Optional ble support is built when MC_BLE_EN is defined.
module mc_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       sign,
   output logic       pcen,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic [1:0] alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
      MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6, RTYPEWB = 4'd7,
      BEQEX   = 4'd8,  ADDIEX  = 4'd9,  ADDIWB = 4'd10, JEX   = 4'd11,
      BLEEX   = 4'd12
   } state_t;

   localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_RTYPE = 6'b000000,
                          OP_BEQ = 6'b000100, OP_BLE = 6'b010110, OP_ADDI = 6'b001000,
                          OP_J = 6'b000010;

   state_t state_q, state_d;
   logic   pcwrite;
   logic   branch;

`ifndef MC_BLE_EN
   logic unused_sign;
   assign unused_sign = sign;
`endif

   always_ff @(posedge clk) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = FETCH;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      alusrca    = 2'b00;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = 3'b010;
      case (state_q)
         FETCH: begin
            alusrcb = 2'b01;
            irwrite = 1'b1;
            pcwrite = 1'b1;
            state_d = DECODE;
         end
         DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = RTYPEEX;
               OP_BEQ:       state_d = BEQEX;
`ifdef MC_BLE_EN
               OP_BLE:       state_d = BLEEX;
`endif
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JEX;
               default:      state_d = FETCH;
            endcase
         end
         MEMADR: begin
            alusrca = 2'b01;
            alusrcb = 2'b10;
            state_d = (op == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            iord    = 1'b1;
            state_d = MEMWB;
         end
         MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         RTYPEEX: begin
            alusrca = 2'b01;
            state_d = RTYPEWB;
            case (funct)
               6'b100010: alucontrol = 3'b110;
               6'b100100: alucontrol = 3'b000;
               6'b100101: alucontrol = 3'b001;
               6'b101010: alucontrol = 3'b111;
               6'b000000: begin
                  alucontrol = 3'b011;
                  alusrca    = 2'b10;
               end
               default:   alucontrol = 3'b010;
            endcase
         end
         RTYPEWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         BEQEX: begin
            alusrca    = 2'b01;
            alucontrol = 3'b110;
            pcsrc      = 2'b01;
            branch     = zero;
         end
`ifdef MC_BLE_EN
         BLEEX: begin
            alusrca    = 2'b01;
            alucontrol = 3'b110;
            pcsrc      = 2'b01;
            branch     = zero | sign;
         end
`endif
         ADDIEX: begin
            alusrca = 2'b01;
            alusrcb = 2'b10;
            state_d = ADDIWB;
         end
         ADDIWB: regwrite = 1'b1;
         JEX: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: state_d = FETCH;
      endcase
      pcen = pcwrite | branch;
      // Reset parks the datapath on FETCH mux settings with every write suppressed.
      if (reset) begin
         pcen       = 1'b0;
         irwrite    = 1'b0;
         memwrite   = 1'b0;
         regwrite   = 1'b0;
         iord       = 1'b0;
         memtoreg   = 1'b0;
         regdst     = 1'b0;
         alusrca    = 2'b00;
         alusrcb    = 2'b01;
         pcsrc      = 2'b00;
         alucontrol = 3'b010;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction expected step lists compared every cycle,
// directed test-plan cases first, then random instructions with random resets.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero, sign;
   logic       pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst;
   logic [1:0] alusrca, alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   localparam int BR_NONE = 0, BR_ALW = 1, BR_EQ = 2, BR_LE = 3;

   typedef struct {
      int         st;
      bit         irw, mw, rw, iord, m2r, rdst;
      bit   [1:0] asa, asb, pcs;
      bit   [2:0] alu;
      int         br;
   } step_t;

   step_t exp_q[$];

   mc_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .sign(sign),
      .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
      .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
   );

   always #5 clk = ~clk;

   function automatic step_t mk(input int st, input bit irw, input bit mw, input bit rw,
                                input bit io, input bit m2r, input bit rdst,
                                input bit [1:0] asa, input bit [1:0] asb, input bit [1:0] pcs,
                                input bit [2:0] alu, input int br);
      step_t s;
      s.st = st; s.irw = irw; s.mw = mw; s.rw = rw; s.iord = io; s.m2r = m2r; s.rdst = rdst;
      s.asa = asa; s.asb = asb; s.pcs = pcs; s.alu = alu; s.br = br;
      return s;
   endfunction

   // Builds the whole life of one instruction as a list of expected cycles.
   task automatic build_expect(input bit [5:0] o, input bit [5:0] f);
      bit [2:0] alu;
      bit [1:0] asa;
      exp_q.push_back(mk(0, 1,0,0, 0,0,0, 2'b00, 2'b01, 2'b00, 3'b010, BR_ALW));
      exp_q.push_back(mk(1, 0,0,0, 0,0,0, 2'b00, 2'b11, 2'b00, 3'b010, BR_NONE));
      case (o)
         6'b100011: begin
            exp_q.push_back(mk(2, 0,0,0, 0,0,0, 2'b01, 2'b10, 2'b00, 3'b010, BR_NONE));
            exp_q.push_back(mk(3, 0,0,0, 1,0,0, 2'b00, 2'b00, 2'b00, 3'b010, BR_NONE));
            exp_q.push_back(mk(4, 0,0,1, 0,1,0, 2'b00, 2'b00, 2'b00, 3'b010, BR_NONE));
         end
         6'b101011: begin
            exp_q.push_back(mk(2, 0,0,0, 0,0,0, 2'b01, 2'b10, 2'b00, 3'b010, BR_NONE));
            exp_q.push_back(mk(5, 0,1,0, 1,0,0, 2'b00, 2'b00, 2'b00, 3'b010, BR_NONE));
         end
         6'b000000: begin
            asa = 2'b01;
            if      (f == 6'b100010) alu = 3'b110;
            else if (f == 6'b100100) alu = 3'b000;
            else if (f == 6'b100101) alu = 3'b001;
            else if (f == 6'b101010) alu = 3'b111;
            else if (f == 6'b000000) begin alu = 3'b011; asa = 2'b10; end
            else                     alu = 3'b010;
            exp_q.push_back(mk(6, 0,0,0, 0,0,0, asa, 2'b00, 2'b00, alu, BR_NONE));
            exp_q.push_back(mk(7, 0,0,1, 0,0,1, 2'b00, 2'b00, 2'b00, 3'b010, BR_NONE));
         end
         6'b000100:
            exp_q.push_back(mk(8, 0,0,0, 0,0,0, 2'b01, 2'b00, 2'b01, 3'b110, BR_EQ));
`ifdef MC_BLE_EN
         6'b010110:
            exp_q.push_back(mk(12, 0,0,0, 0,0,0, 2'b01, 2'b00, 2'b01, 3'b110, BR_LE));
`endif
         6'b001000: begin
            exp_q.push_back(mk(9, 0,0,0, 0,0,0, 2'b01, 2'b10, 2'b00, 3'b010, BR_NONE));
            exp_q.push_back(mk(10, 0,0,1, 0,0,0, 2'b00, 2'b00, 2'b00, 3'b010, BR_NONE));
         end
         6'b000010:
            exp_q.push_back(mk(11, 0,0,0, 0,0,0, 2'b00, 2'b00, 2'b10, 3'b010, BR_ALW));
         default: ;
      endcase
   endtask

   function automatic bit [19:0] dut_vec();
      return {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
              alusrca, alusrcb, pcsrc, alucontrol, state};
   endfunction

   task automatic check_vec(input string name, input bit [19:0] exp_v, input bit [19:0] mask);
      checks++;
      if ((dut_vec() & mask) !== (exp_v & mask)) begin
         errors++;
         $display("FAIL %s: got %h expected %h (mask %h) at %0t", name, dut_vec(), exp_v, mask, $time);
      end
   endtask

   // Checks the current cycle against the head of the model queue, then retires it.
   task automatic check_cycle(input bit st_known);
      step_t s;
      bit    pcen_e;
      s = exp_q[0];
      if (reset) begin
         check_vec("reset_outputs",
                   {7'b0, 2'b00, 2'b01, 2'b00, 3'b010, 4'(s.st)},
                   st_known ? 20'hFFFFF : 20'hFFFF0);
         exp_q.delete();
      end else begin
         case (s.br)
            BR_ALW:  pcen_e = 1'b1;
            BR_EQ:   pcen_e = zero;
            BR_LE:   pcen_e = zero | sign;
            default: pcen_e = 1'b0;
         endcase
         check_vec($sformatf("step_st%0d", s.st),
                   {pcen_e, s.irw, s.mw, s.rw, s.iord, s.m2r, s.rdst,
                    s.asa, s.asb, s.pcs, s.alu, 4'(s.st)}, 20'hFFFFF);
         void'(exp_q.pop_front());
      end
   endtask

   task automatic model_len(input string name, input bit [5:0] o, input int want);
      build_expect(o, 6'b100000);
      checks++;
      if (exp_q.size() != want) begin
         errors++;
         $display("FAIL cpi_%s: got %0d required %0d", name, exp_q.size(), want);
      end
      exp_q.delete();
   endtask

   // Directed instructions: op, funct, fixed zero, fixed sign.
   bit [5:0] d_op[9]    = '{6'b100011, 6'b000000, 6'b000100, 6'b000100, 6'b010110,
                            6'b010110, 6'b111111, 6'b101011, 6'b000010};
   bit [5:0] d_funct[9] = '{6'b0, 6'b000000, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0};
   bit       d_zero[9]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
   bit       d_sign[9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
   bit [5:0] r_op[8]    = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b010110,
                            6'b001000, 6'b000010, 6'b000000};
   bit [5:0] r_funct[7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                            6'b000000, 6'b111111};

   initial begin
      int  d_idx;
      int  cyc;
      bit  fix_zs, fz, fs;

      model_len("lw", 6'b100011, 5);
      model_len("sw", 6'b101011, 4);
      model_len("rtype", 6'b000000, 4);
      model_len("addi", 6'b001000, 4);
      model_len("beq", 6'b000100, 3);
      model_len("j", 6'b000010, 3);
      model_len("illegal", 6'b111111, 2);
`ifdef MC_BLE_EN
      model_len("ble", 6'b010110, 3);
`else
      model_len("ble_off", 6'b010110, 2);
`endif

      reset = 1'b1; op = '0; funct = '0; zero = 1'b0; sign = 1'b0;
      build_expect(6'b0, 6'b0);
      @(negedge clk); #1 check_cycle(1'b0);
      build_expect(6'b0, 6'b0);
      @(negedge clk); #1 check_cycle(1'b1);
      reset = 1'b0;
      d_idx = 0;
      fix_zs = 1'b0; fz = 1'b0; fs = 1'b0;

      for (cyc = 0; cyc < 3000; cyc++) begin
         if (cyc != 0) @(negedge clk);
         if (exp_q.size() == 0) begin
            if (d_idx < 9) begin
               op = d_op[d_idx]; funct = d_funct[d_idx];
               fix_zs = 1'b1; fz = d_zero[d_idx]; fs = d_sign[d_idx];
               d_idx++;
            end else begin
               fix_zs = 1'b0;
               if ($urandom_range(0, 9) == 0) op = 6'($urandom);
               else                           op = r_op[$urandom_range(0, 7)];
               if ($urandom_range(0, 4) == 0) funct = 6'($urandom);
               else                           funct = r_funct[$urandom_range(0, 6)];
            end
            build_expect(op, funct);
         end
         zero  = fix_zs ? fz : 1'($urandom);
         sign  = fix_zs ? fs : 1'($urandom);
         reset = (d_idx >= 9) && ($urandom_range(0, 29) == 0);
         #1 check_cycle(1'b1);
      end

      @(negedge clk);
      reset = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
